// File: rtl/mux_sel_arbiter.sv
// Round-robin feeder for a 2:1 word mux: two valid/ready sources are parked in
// one-entry holding registers and granted alternately onto the mux output.
module mux_sel_arbiter #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_a_valid,
   output logic             o_a_ready,
   input  logic [0:WIDTH-1] i_a_data,
   input  logic             i_b_valid,
   output logic             o_b_ready,
   input  logic [0:WIDTH-1] i_b_data,
   output logic [0:WIDTH-1] o_mux_a,
   output logic [0:WIDTH-1] o_mux_b,
   output logic             o_sel,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [CNT_W-1:0] o_a_cnt,
   output logic [CNT_W-1:0] o_b_cnt
);

   typedef enum logic [1:0] {IDLE, SEND_A, SEND_B} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_a_full;
   logic             r_b_full;
   logic             r_sel;
   logic             w_sel_nxt;
   logic [0:WIDTH-1] r_mux_a;
   logic [0:WIDTH-1] r_mux_b;
   logic [CNT_W-1:0] r_a_cnt;
   logic [CNT_W-1:0] r_b_cnt;
   logic             w_a_done;
   logic             w_b_done;
   logic             w_a_acc;
   logic             w_b_acc;
   logic             w_a_elig;
   logic             w_b_elig;
   logic             w_decide;

   assign w_a_done  = (r_state == SEND_A) && i_out_ready;
   assign w_b_done  = (r_state == SEND_B) && i_out_ready;
   assign o_a_ready = !r_a_full || w_a_done;
   assign o_b_ready = !r_b_full || w_b_done;
   assign w_a_acc   = i_a_valid && o_a_ready;
   assign w_b_acc   = i_b_valid && o_b_ready;
   // A source whose word is leaving this cycle must not be re-granted at once.
   assign w_a_elig  = r_a_full && !w_a_done;
   assign w_b_elig  = r_b_full && !w_b_done;
   assign w_decide  = (r_state == IDLE) || w_a_done || w_b_done;

   // r_sel doubles as last_grant: both are set on entering a send state and
   // both hold in IDLE, with reset value B (0) so A wins the first tie.
   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      o_out_valid = 1'b0;
      if (w_decide) begin
         if (w_a_elig && w_b_elig) begin
            w_state_nxt = r_sel ? SEND_B : SEND_A;
         end else if (w_a_elig) begin
            w_state_nxt = SEND_A;
         end else if (w_b_elig) begin
            w_state_nxt = SEND_B;
         end else begin
            w_state_nxt = IDLE;
         end
      end
      if (w_state_nxt == SEND_A) begin
         w_sel_nxt = 1'b1;
      end else if (w_state_nxt == SEND_B) begin
         w_sel_nxt = 1'b0;
      end
      if (r_state != IDLE) begin
         o_out_valid = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state  <= IDLE;
         r_sel    <= 1'b0;
         r_a_full <= 1'b0;
         r_b_full <= 1'b0;
         r_mux_a  <= '0;
         r_mux_b  <= '0;
         r_a_cnt  <= '0;
         r_b_cnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
         if (w_a_acc) begin
            r_a_full <= 1'b1;
            r_mux_a  <= i_a_data;
         end else if (w_a_done) begin
            r_a_full <= 1'b0;
         end
         if (w_b_acc) begin
            r_b_full <= 1'b1;
            r_mux_b  <= i_b_data;
         end else if (w_b_done) begin
            r_b_full <= 1'b0;
         end
         if (w_a_done) begin
            r_a_cnt <= r_a_cnt + CNT_ONE;
         end
         if (w_b_done) begin
            r_b_cnt <= r_b_cnt + CNT_ONE;
         end
      end
   end

   assign o_mux_a = r_mux_a;
   assign o_mux_b = r_mux_b;
   assign o_sel   = r_sel;
   assign o_a_cnt = r_a_cnt;
   assign o_b_cnt = r_b_cnt;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: per-source word scoreboards checked at each
// output completion, plus directed latency/backpressure/reset/wrap checks.
module tb_mux_sel_arbiter;
   localparam int W = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n, a_valid, b_valid, out_ready;
   logic [0:W-1] a_data, b_data;
   logic         a_ready, b_ready, sel, out_valid;
   logic [0:W-1] mux_a, mux_b;
   logic [7:0]   a_cnt, b_cnt;
   logic         a_ready2, b_ready2, sel2, out_valid2;
   logic [0:W-1] mux_a2, mux_b2;
   logic [1:0]   a_cnt2, b_cnt2;

   mux_sel_arbiter #(.WIDTH(W), .CNT_W(8)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_a_valid(a_valid), .o_a_ready(a_ready), .i_a_data(a_data),
      .i_b_valid(b_valid), .o_b_ready(b_ready), .i_b_data(b_data),
      .o_mux_a(mux_a), .o_mux_b(mux_b), .o_sel(sel),
      .o_out_valid(out_valid), .i_out_ready(out_ready),
      .o_a_cnt(a_cnt), .o_b_cnt(b_cnt)
   );

   mux_sel_arbiter #(.WIDTH(W), .CNT_W(2)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_a_valid(a_valid), .o_a_ready(a_ready2), .i_a_data(a_data),
      .i_b_valid(b_valid), .o_b_ready(b_ready2), .i_b_data(b_data),
      .o_mux_a(mux_a2), .o_mux_b(mux_b2), .o_sel(sel2),
      .o_out_valid(out_valid2), .i_out_ready(out_ready),
      .o_a_cnt(a_cnt2), .o_b_cnt(b_cnt2)
   );

   int n_vec = 0;
   int n_err = 0;
   logic [0:W-1] qa[$];
   logic [0:W-1] qb[$];
   int n_a_done = 0;
   int n_b_done = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard: words pushed on source handshake, popped on output completion.
   always @(negedge clk) begin
      if (!rst_n) begin
         qa.delete();
         qb.delete();
         n_a_done = 0;
         n_b_done = 0;
      end else begin
         chk("a_cnt", {24'd0, a_cnt}, n_a_done % 256);
         chk("b_cnt", {24'd0, b_cnt}, n_b_done % 256);
         chk("a_cnt_w2", {30'd0, a_cnt2}, n_a_done % 4);
         if (out_valid && out_ready) begin
            if (sel) begin
               if (qa.size() == 0) chk("a_no_word", 1, 0);
               else chk("a_word", {28'd0, mux_a}, {28'd0, qa.pop_front()});
               n_a_done++;
            end else begin
               if (qb.size() == 0) chk("b_no_word", 1, 0);
               else chk("b_word", {28'd0, mux_b}, {28'd0, qb.pop_front()});
               n_b_done++;
            end
         end
         if (a_valid && a_ready) qa.push_back(a_data);
         if (b_valid && b_ready) qb.push_back(b_data);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
   endtask

   task automatic do_reset();
      idle_in();
      out_ready = 1'b1;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      // 1: reset with all inputs high
      rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
      a_data = 4'hF; b_data = 4'hF;
      tick();
      tick();
      chk("rst_mux_a", {28'd0, mux_a}, 0);
      chk("rst_mux_b", {28'd0, mux_b}, 0);
      chk("rst_sel", {31'd0, sel}, 0);
      chk("rst_out_valid", {31'd0, out_valid}, 0);
      chk("rst_a_cnt", {24'd0, a_cnt}, 0);
      chk("rst_b_cnt", {24'd0, b_cnt}, 0);
      chk("rst_out_valid_w2", {31'd0, out_valid2}, 0);
      chk("rst_sel_w2", {31'd0, sel2}, 0);
      chk("rst_mux_w2", {24'd0, mux_a2, mux_b2}, 0);
      idle_in();
      rst_n = 1'b1;
      tick();
      chk("rel_a_ready", {31'd0, a_ready}, 1);
      chk("rel_b_ready", {31'd0, b_ready}, 1);
      chk("rel_ready_w2", {30'd0, a_ready2, b_ready2}, 3);

      // 2: single A word latency
      do_reset();
      a_valid = 1'b1; a_data = 4'b1010;
      tick();
      idle_in();
      chk("t2_c1_valid", {31'd0, out_valid}, 0);
      tick();
      chk("t2_c2_valid", {31'd0, out_valid}, 1);
      chk("t2_c2_sel", {31'd0, sel}, 1);
      chk("t2_c2_mux_a", {28'd0, mux_a}, 4'b1010);
      tick();
      chk("t2_c3_a_cnt", {24'd0, a_cnt}, 1);
      chk("t2_c3_valid", {31'd0, out_valid}, 0);

      // 3: simultaneous first accept, A first then B, no gap
      do_reset();
      a_valid = 1'b1; a_data = 4'd3; b_valid = 1'b1; b_data = 4'd5;
      tick();
      idle_in();
      tick();
      chk("t3_c2_valid", {31'd0, out_valid}, 1);
      chk("t3_c2_sel", {31'd0, sel}, 1);
      chk("t3_c2_mux_a", {28'd0, mux_a}, 3);
      tick();
      chk("t3_c3_valid", {31'd0, out_valid}, 1);
      chk("t3_c3_sel", {31'd0, sel}, 0);
      chk("t3_c3_mux_b", {28'd0, mux_b}, 5);
      tick();
      chk("t3_a_cnt", {24'd0, a_cnt}, 1);
      chk("t3_b_cnt", {24'd0, b_cnt}, 1);
      chk("t3_c4_valid", {31'd0, out_valid}, 0);

      // 4: backpressure on a granted A word
      do_reset();
      out_ready = 1'b0;
      a_valid = 1'b1; a_data = 4'h6;
      tick();
      idle_in();
      tick();
      a_valid = 1'b1; a_data = 4'h9;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t4_a_ready", {31'd0, a_ready}, 0);
         chk("t4_valid", {31'd0, out_valid}, 1);
         chk("t4_sel", {31'd0, sel}, 1);
         chk("t4_mux_a", {28'd0, mux_a}, 4'h6);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("t4_release_ready", {31'd0, a_ready}, 1);
      tick();
      idle_in();
      chk("t4_gap_valid", {31'd0, out_valid}, 0);
      chk("t4_new_mux_a", {28'd0, mux_a}, 4'h9);
      tick();
      chk("t4_resend_valid", {31'd0, out_valid}, 1);
      chk("t4_resend_sel", {31'd0, sel}, 1);
      tick();
      chk("t4_a_cnt", {24'd0, a_cnt}, 2);

      // 5: sustained round-robin
      do_reset();
      a_valid = 1'b1; b_valid = 1'b1;
      for (int c = 0; c < 22; c++) begin
         a_data = W'($urandom_range(0, 15));
         b_data = W'($urandom_range(0, 15));
         tick();
         if (c + 1 >= 2) begin
            chk("t5_valid", {31'd0, out_valid}, 1);
            chk("t5_sel", {31'd0, sel}, ((c + 1) % 2 == 0) ? 1 : 0);
         end
      end
      idle_in();
      chk("t5_balance", (a_cnt >= b_cnt) ? a_cnt - b_cnt : b_cnt - a_cnt, 32'd0 + ((a_cnt > b_cnt + 8'd1 || b_cnt > a_cnt + 8'd1) ? 1 : 0) * 100);
      chk("t5_balance_le1", ((a_cnt >= b_cnt ? a_cnt - b_cnt : b_cnt - a_cnt) <= 8'd1) ? 1 : 0, 1);
      repeat (4) tick();
      chk("t5_drain_a", qa.size(), 0);
      chk("t5_drain_b", qb.size(), 0);

      // 6a: reset during SEND_B drops held words and counters
      do_reset();
      b_valid = 1'b1; b_data = 4'h2;
      tick();
      idle_in();
      repeat (3) tick();
      chk("t6_b_cnt_pre", {24'd0, b_cnt}, 1);
      out_ready = 1'b0;
      b_valid = 1'b1; b_data = 4'h7;
      tick();
      idle_in();
      a_valid = 1'b1; a_data = 4'hC;
      tick();
      idle_in();
      chk("t6_in_send_b", {30'd0, out_valid, sel}, 2'b10);
      rst_n = 1'b0;
      a_valid = 1'b1; b_valid = 1'b1; a_data = 4'hE; b_data = 4'hD;
      tick();
      idle_in();
      rst_n = 1'b1;
      out_ready = 1'b1;
      chk("t6_valid", {31'd0, out_valid}, 0);
      chk("t6_b_cnt", {24'd0, b_cnt}, 0);
      chk("t6_mux", {24'd0, mux_a, mux_b}, 0);
      chk("t6_ready", {30'd0, a_ready, b_ready}, 3);
      repeat (3) begin
         tick();
         chk("t6_stays_idle", {31'd0, out_valid}, 0);
      end

      // 6b: counter wrap with CNT_W=2
      do_reset();
      for (int k = 0; k < 5; k++) begin
         a_valid = 1'b1; a_data = W'(k);
         tick();
         idle_in();
         repeat (2) tick();
      end
      chk("t6_wrap_cnt_w2", {30'd0, a_cnt2}, 1);
      chk("t6_wrap_cnt_w8", {24'd0, a_cnt}, 5);

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
